// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   BCD digit constants, FSM state encoding and a width helper for the
//   iteration counter.
package bcd_pkg;

  localparam int         BCD_DIG_W   = 4;
  localparam logic [3:0] BCD_DIG_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ_THR = 4'd8;
  localparam logic [3:0] BCD_ADJ     = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to hold 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction.
//   i_digit : 4-bit BCD field after the right shift
//   o_digit : i_digit - 3 when i_digit >= 8, otherwise i_digit unchanged
// Subtraction only happens for values >= 8, so the result never underflows.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] i_digit,
  output logic [BCD_DIG_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THR) ? (i_digit - BCD_ADJ) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : bcd_in is valid
//   in_ready  : converter can accept (IDLE only)
//   bcd_in    : NDIGITS packed BCD digits, units in the LSB nibble
//   out_valid : bin_out/err valid, held until accepted
//   out_ready : downstream accepts result
//   bin_out   : binary value of bcd_in (0 on error)
//   err       : some input digit was > 9
// One shift/adjust iteration per clock; BIN_W iterations per conversion.
//
//   state  | meaning
//   S_IDLE | waiting for an input handshake
//   S_CONV | shifting, one iteration per clock
//   S_DONE | result held until out_ready
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int BIN_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_W-1:0]       bin_out,
  output logic                   err
);

  localparam int BCD_W = BCD_DIG_W * NDIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             r_state, w_state_nxt;
  logic [SR_W-1:0]    r_sr, w_sr_nxt;
  logic [SR_W-1:0]    w_shift, w_adj;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BIN_W-1:0]   r_bin, w_bin_nxt;
  logic               r_err, w_err_nxt;
  logic               w_digit_bad;

  assign w_shift = r_sr >> 1;

  // Binary field passes through; each BCD field gets its own corrector.
  assign w_adj[BIN_W-1:0] = w_shift[BIN_W-1:0];

  for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (w_shift[BIN_W + BCD_DIG_W*g +: BCD_DIG_W]),
      .o_digit (w_adj  [BIN_W + BCD_DIG_W*g +: BCD_DIG_W])
    );
  end

  always_comb begin
    w_digit_bad = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if (bcd_in[BCD_DIG_W*k +: BCD_DIG_W] > BCD_DIG_MAX) w_digit_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bin   <= w_bin_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_bin_nxt   = r_bin;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_digit_bad) begin
            w_bin_nxt   = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_sr_nxt    = {bcd_in, {BIN_W{1'b0}}};
            w_cnt_nxt   = '0;
            w_state_nxt = S_CONV;
          end
        end
      end
      S_CONV: begin
        w_sr_nxt  = w_adj;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          // Final iteration: the binary field of the adjusted value is the result.
          w_bin_nxt   = w_adj[BIN_W-1:0];
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bin_out   = r_bin;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
module tb_bcd_to_bin_seq;

  localparam int NDIGITS = 3;
  localparam int BIN_W   = 10;
  localparam int BCD_W   = 4 * NDIGITS;
  localparam int MAX_LAT = 40;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [BCD_W-1:0] bcd_in;
  logic             out_valid;
  logic             out_ready;
  logic [BIN_W-1:0] bin_out;
  logic             err;

  int n_cmp;
  int n_mis;

  bcd_to_bin_seq #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BCD_W-1:0] bcd;
    int               bin;
    int               err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // Forward double-dabble encoder for 8-bit values.
  function automatic logic [BCD_W-1:0] dd_encode(input logic [7:0] b);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      for (int d = 0; d < NDIGITS; d++) begin
        if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      end
      r = {r[BCD_W-2:0], b[i]};
    end
    return r;
  endfunction

  // Drives one conversion from an IDLE state and checks result, latency
  // (edges after the accept edge until out_valid) and hold under backpressure.
  task automatic do_conv(input string tag, input logic [BCD_W-1:0] bcd,
                         input int exp_bin, input int exp_err, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < MAX_LAT) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, " in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    bcd_in   = bcd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcd_in   = ~bcd;
    lat = 0;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, lat, (exp_err != 0) ? 0 : BIN_W);
    chk({tag, " bin_out"}, int'(bin_out), exp_bin);
    chk({tag, " err"}, int'(err), exp_err);
    if (exp_err == 0)
      chk({tag, " bcd field zero"}, int'(dut.r_sr[BCD_W+BIN_W-1:BIN_W]), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1) begin
        chk({tag, " hold valid"}, int'(out_valid), 1);
        chk({tag, " hold bin_out"}, int'(bin_out), exp_bin);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post out_valid"}, int'(out_valid), 0);
    chk({tag, " post in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int v;
    int seen;
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;

    tbl[0] = '{12'h255, 255, 0};
    tbl[1] = '{12'h999, 999, 0};
    tbl[2] = '{12'h000,   0, 0};
    tbl[3] = '{12'h100, 100, 0};
    tbl[4] = '{12'h1A3,   0, 1};
    tbl[5] = '{12'h00F,   0, 1};
    tbl[6] = '{12'hB00,   0, 1};
    tbl[7] = '{12'h909, 909, 0};
    tbl[8] = '{12'h080,  80, 0};
    tbl[9] = '{12'h001,   1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset bin_out", int'(bin_out), 0);
    chk("reset err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      do_conv($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].bin, tbl[i].err, i % 3);

    // Asynchronous reset while DONE holds a result: clears without a clock edge.
    in_valid = 1'b1;
    bcd_in   = 12'h255;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (BIN_W) @(posedge clk);
    #1;
    chk("pre-reset out_valid", int'(out_valid), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async reset in_ready", int'(in_ready), 1);
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset bin_out", int'(bin_out), 0);
    chk("async reset err", int'(err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Backpressure: 042 held 20 cycles while a new input is offered and ignored.
    in_valid = 1'b1;
    bcd_in   = 12'h042;
    @(posedge clk); #1;
    bcd_in   = 12'h123;
    repeat (BIN_W - 1) @(posedge clk);
    #1;
    seen = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(out_valid && bin_out == 10'd42 && !err && !in_ready)) seen = 0;
    end
    chk("bp stable 20 cycles", seen, 1);
    chk("bp bin_out", int'(bin_out), 42);
    chk("bp in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp release out_valid", int'(out_valid), 0);
    chk("bp release in_ready", int'(in_ready), 1);
    chk("bp bin_out kept", int'(bin_out), 42);
    @(posedge clk); #1;
    chk("bp ignored input", int'(out_valid), 0);

    // Abort 777 at iteration 5, then a clean conversion of 031.
    in_valid = 1'b1;
    bcd_in   = 12'h777;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort no out_valid", seen, 0);
    do_conv("after abort", 12'h031, 31, 0, 0);

    // Full sweep; 0..255 fed from a double-dabble encoder for the round trip.
    for (int n = 0; n < 1000; n++) begin
      logic [BCD_W-1:0] b;
      v = n;
      b = (n < 256) ? dd_encode(8'(n)) : to_bcd(n);
      do_conv($sformatf("sweep %0d", n), b, v, 0, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
